// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and defaults for the fetch front end.
// Entry layout is common to the queue and decode.
package fetch_pkg;

  localparam int FE_XLEN = 64;
  localparam int FE_ILEN = 32;
  localparam int FE_IALIGN_BYTES = 4;
  localparam logic [63:0] FE_RESET_PC = 64'd512;

  typedef struct packed {
    logic [FE_XLEN-1:0] pc;
    logic [FE_ILEN-1:0] ir;
    logic               iam;
  } fe_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Instruction-memory and decode handshake bundle.
// master = fetch unit side, slave = memory/decode side.
interface fetch_queue_unit_if
  import fetch_pkg::*;
#(
  parameter int XLEN = FE_XLEN,
  parameter int ILEN = FE_ILEN
);

  logic            IMEM_REQ_V;
  logic [XLEN-1:0] IMEM_REQ_PC;
  logic            IMEM_REQ_RDY;
  logic            IMEM_RSP_V;
  logic [ILEN-1:0] IMEM_RSP_IR;
  logic            DE_V;
  logic [XLEN-1:0] DE_PC;
  logic [XLEN-1:0] DE_NPC;
  logic [ILEN-1:0] DE_IR;
  logic            DE_IAM;
  logic            DE_RDY;

  modport master (
    output IMEM_REQ_V, IMEM_REQ_PC,
    input  IMEM_REQ_RDY,
    input  IMEM_RSP_V, IMEM_RSP_IR,
    output DE_V, DE_PC, DE_NPC, DE_IR, DE_IAM,
    input  DE_RDY
  );

  modport slave (
    input  IMEM_REQ_V, IMEM_REQ_PC,
    output IMEM_REQ_RDY,
    output IMEM_RSP_V, IMEM_RSP_IR,
    input  DE_V, DE_PC, DE_NPC, DE_IR, DE_IAM,
    output DE_RDY
  );

endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// First-word-fall-through synchronous FIFO with flush.
// Pop on empty is ignored; push when full is illegal.
module fe_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_full;

  assign w_pop   = i_pop && (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign o_data  = r_mem[r_rd];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

  // storage write; no reset needed, occupancy guards reads
  always_ff @(posedge clk) begin
    if (i_push && !i_flush)
      r_mem[r_wr] <= i_data;
  end

  // pointers and occupancy, cleared by flush
  always_ff @(posedge clk) begin
    if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

  // upstream credit logic must never overfill
  always_ff @(posedge clk) begin
    if (!i_flush)
      assert (!(i_push && !w_pop && w_full));
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: PC gen, credit-throttled imem
// requests, in-flight PC tracking and decode queue.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = FE_XLEN,
  parameter int              ILEN         = FE_ILEN,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_PC     = XLEN'(FE_RESET_PC),
  parameter int              IALIGN_BYTES = FE_IALIGN_BYTES
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       CS_V,
  input  logic [XLEN-1:0]            CS_VEC,
  input  logic                       REDIRECT_V,
  input  logic [XLEN-1:0]            REDIRECT_PC,
  input  logic                       STALL,
  fetch_queue_unit_if.master         bus,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] AMASK =
    XLEN'(IALIGN_BYTES - 1);

  logic [XLEN-1:0] r_fe_pc;
  logic [CW-1:0]   r_out;
  logic [CW-1:0]   r_drop;
  logic            r_halted;

  logic            w_flush;
  logic            w_clr;
  logic            w_aligned;
  logic            w_credit;
  logic            w_req_v;
  logic            w_fire;
  logic            w_rsp;
  logic            w_drop_rsp;
  logic            w_rsp_push;
  logic            w_iam_push;
  logic            w_q_push;
  logic            w_q_pop;
  logic            w_q_valid;
  logic [CW-1:0]   w_q_count;
  fe_entry_t       w_q_din;
  fe_entry_t       w_q_head;
  logic [XLEN-1:0] w_pc_head;
  logic            w_pc_valid;
  logic [CW-1:0]   w_pc_count;

  assign w_flush   = !RESET && (CS_V || REDIRECT_V);
  assign w_clr     = RESET || w_flush;
  assign w_aligned = ((r_fe_pc & AMASK) == '0);
  assign w_credit  = ({1'b0, w_q_count} + {1'b0, r_out})
                     < (CW+1)'(DEPTH);

  assign w_req_v = !w_clr && !STALL && !r_halted
                   && w_aligned && w_credit;
  assign w_fire  = w_req_v && bus.IMEM_REQ_RDY;

  assign w_rsp      = !RESET && bus.IMEM_RSP_V;
  assign w_drop_rsp = w_rsp && (r_drop != '0);
  assign w_rsp_push = w_rsp && !w_flush && (r_drop == '0);

  // fault entry once nothing older can still land
  assign w_iam_push = !w_clr && !w_aligned && !r_halted
                      && (r_out == '0) && (r_drop == '0)
                      && (w_q_count < CW'(DEPTH));

  assign w_q_push = w_rsp_push || w_iam_push;
  assign w_q_pop  = !w_clr && w_q_valid && bus.DE_RDY;

  // queue entry source: fault marker or memory response
  always_comb begin
    w_q_din = '0;
    if (w_iam_push) begin
      w_q_din.pc  = r_fe_pc;
      w_q_din.iam = 1'b1;
    end else begin
      w_q_din.pc = w_pc_head;
      w_q_din.ir = bus.IMEM_RSP_IR;
    end
  end

  // PC gen, outstanding/drop counters, halt flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_fe_pc  <= RESET_PC;
      r_out    <= '0;
      r_drop   <= '0;
      r_halted <= 1'b0;
    end else if (w_flush) begin
      r_fe_pc  <= CS_V ? CS_VEC : REDIRECT_PC;
      r_halted <= 1'b0;
      r_out    <= r_out - CW'(w_rsp);
      r_drop   <= r_out - CW'(w_rsp);
    end else begin
      if (w_fire)
        r_fe_pc <= r_fe_pc + XLEN'(4);
      r_out <= r_out + CW'(w_fire) - CW'(w_rsp);
      if (w_drop_rsp)
        r_drop <= r_drop - CW'(1);
      if (w_iam_push)
        r_halted <= 1'b1;
    end
  end

  fe_sync_fifo #(
    .WIDTH ($bits(fe_entry_t)),
    .DEPTH (DEPTH)
  ) u_iq (
    .clk     (CLK),
    .i_flush (w_clr),
    .i_push  (w_q_push),
    .i_data  (w_q_din),
    .i_pop   (w_q_pop),
    .o_data  (w_q_head),
    .o_valid (w_q_valid),
    .o_count (w_q_count)
  );

  fe_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pcq (
    .clk     (CLK),
    .i_flush (w_clr),
    .i_push  (w_fire),
    .i_data  (r_fe_pc),
    .i_pop   (w_rsp_push),
    .o_data  (w_pc_head),
    .o_valid (w_pc_valid),
    .o_count (w_pc_count)
  );

  // every live response needs its recorded PC
  always_ff @(posedge CLK) begin
    if (!w_clr) begin
      assert (!w_rsp_push || w_pc_valid);
      assert (w_pc_count <= r_out);
    end
  end

  assign bus.IMEM_REQ_V  = w_req_v;
  assign bus.IMEM_REQ_PC = r_fe_pc;
  assign bus.DE_V        = !RESET && w_q_valid;
  assign bus.DE_PC       = w_q_head.pc;
  assign bus.DE_NPC      = w_q_head.pc + XLEN'(4);
  assign bus.DE_IR       = w_q_head.ir;
  assign bus.DE_IAM      = w_q_head.iam;
  assign COUNT           = RESET ? '0 : w_q_count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: vector table, corner
// sequences, randomized run vs queue-level model.
module tb_fetch_queue_unit;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int DEPTH = 4;
  localparam int CW = 3;
  localparam logic [63:0] RPC = 64'd512;

  logic            CLK = 1'b0;
  logic            RESET, CS_V, REDIRECT_V, STALL;
  logic [XLEN-1:0] CS_VEC, REDIRECT_PC;
  logic [CW-1:0]   COUNT;

  fetch_queue_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

  fetch_queue_unit #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH),
    .RESET_PC(RPC), .IALIGN_BYTES(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CS_V(CS_V),
    .CS_VEC(CS_VEC), .REDIRECT_V(REDIRECT_V),
    .REDIRECT_PC(REDIRECT_PC), .STALL(STALL),
    .bus(bus), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] pc; logic [31:0] ir; bit iam;
  } ent_t;
  typedef struct { logic [63:0] pc; bit stale; } fl_t;
  typedef struct { logic [63:0] pc; int due; } mr_t;
  typedef struct {
    bit rst, derdy, e_reqv;
    logic [63:0] e_pc;
    bit e_dev;
    logic [63:0] e_depc;
    int e_cnt;
  } vec_t;

  ent_t mq[$];
  fl_t  mf[$];
  mr_t  mp[$];
  logic [63:0] m_pc;
  bit   m_halt, mchk;
  int   last_due, cyc, checks, fails, lat_lo, lat_hi;

  bit t_rst, t_cs, t_redir, t_stall, t_rdy, t_derdy;
  logic [63:0] t_csvec, t_rpc;

  bit obs_reqv, obs_dev, obs_iam;
  logic [63:0] obs_reqpc, obs_depc;
  logic [31:0] obs_deir;
  int obs_cnt;

  function automatic logic [31:0] ir_of(logic [63:0] pc);
    return pc[31:0] ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s cyc=%0d act=%h exp=%h",
                 nm, cyc, act, exp);
    end
  endtask

  task automatic idle();
    t_rst = 0; t_cs = 0; t_redir = 0; t_stall = 0;
    t_rdy = 1; t_derdy = 1;
  endtask

  task automatic cycle();
    bit rsp, fire, pop, flush, aligned, ereqv, iam;
    fl_t f;
    ent_t e;
    mr_t r;
    int d;
    f.pc = '0; f.stale = 0;
    RESET = t_rst; CS_V = t_cs; CS_VEC = t_csvec;
    REDIRECT_V = t_redir; REDIRECT_PC = t_rpc;
    STALL = t_stall;
    bus.IMEM_REQ_RDY = t_rdy; bus.DE_RDY = t_derdy;
    rsp = (mp.size() > 0) && (mp[0].due <= cyc);
    bus.IMEM_RSP_V = rsp;
    bus.IMEM_RSP_IR = rsp ? ir_of(mp[0].pc) : $urandom;
    #1;
    flush = !t_rst && (t_cs || t_redir);
    aligned = (m_pc[1:0] == 2'b00);
    ereqv = !t_rst && !flush && !t_stall && !m_halt
            && aligned && (mq.size() + mf.size() < DEPTH);
    obs_reqv = bus.IMEM_REQ_V; obs_reqpc = bus.IMEM_REQ_PC;
    obs_dev = bus.DE_V; obs_depc = bus.DE_PC;
    obs_deir = bus.DE_IR; obs_iam = bus.DE_IAM;
    obs_cnt = int'(COUNT);
    if (mchk) begin
      chk("req_v", 64'(bus.IMEM_REQ_V), 64'(ereqv));
      if (ereqv) chk("req_pc", bus.IMEM_REQ_PC, m_pc);
      chk("de_v", 64'(bus.DE_V),
          64'(!t_rst && mq.size() != 0));
      chk("count", 64'(COUNT),
          t_rst ? 64'd0 : 64'(mq.size()));
      if (!t_rst && mq.size() != 0) begin
        chk("de_pc", bus.DE_PC, mq[0].pc);
        chk("de_npc", bus.DE_NPC, mq[0].pc + 64'd4);
        chk("de_ir", 64'(bus.DE_IR), 64'(mq[0].ir));
        chk("de_iam", 64'(bus.DE_IAM), 64'(mq[0].iam));
      end
    end
    fire = ereqv && t_rdy;
    pop = !t_rst && !flush && mq.size() != 0 && t_derdy;
    iam = !t_rst && !flush && !aligned && !m_halt
          && mf.size() == 0 && mq.size() < DEPTH;
    if (t_rst) begin
      mq.delete(); mf.delete(); mp.delete();
      m_pc = RPC; m_halt = 0; last_due = 0;
    end else begin
      if (rsp) begin
        f = mf.pop_front();
        void'(mp.pop_front());
      end
      if (flush) begin
        foreach (mf[i]) mf[i].stale = 1;
        mq.delete();
        m_pc = t_cs ? t_csvec : t_rpc;
        m_halt = 0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (rsp && !f.stale) begin
          e.pc = f.pc; e.ir = ir_of(f.pc); e.iam = 0;
          mq.push_back(e);
        end
        if (iam) begin
          e.pc = m_pc; e.ir = '0; e.iam = 1;
          mq.push_back(e);
          m_halt = 1;
        end
        if (fire) begin
          f.pc = m_pc; f.stale = 0;
          mf.push_back(f);
          d = cyc + int'($urandom_range(lat_lo, lat_hi));
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          r.pc = m_pc; r.due = d;
          mp.push_back(r);
          m_pc = m_pc + 64'd4;
        end
      end
    end
    @(posedge CLK); #1;
    cyc++;
  endtask

  vec_t tv[11];

  initial begin
    bit seen;
    int nreq, niam;
    checks = 0; fails = 0; cyc = 0; mchk = 0;
    lat_lo = 1; lat_hi = 1; last_due = 0;
    m_pc = RPC; m_halt = 0;
    t_csvec = '0; t_rpc = '0;

    tv[0]  = '{1, 1, 0, 64'd0,   0, 64'd0,   0};
    tv[1]  = '{0, 1, 1, 64'd512, 0, 64'd0,   0};
    tv[2]  = '{0, 1, 1, 64'd516, 0, 64'd0,   0};
    tv[3]  = '{0, 1, 1, 64'd520, 1, 64'd512, 1};
    tv[4]  = '{0, 1, 1, 64'd524, 1, 64'd516, 1};
    tv[5]  = '{0, 0, 1, 64'd528, 1, 64'd520, 1};
    tv[6]  = '{0, 0, 1, 64'd532, 1, 64'd520, 2};
    tv[7]  = '{0, 0, 0, 64'd0,   1, 64'd520, 3};
    tv[8]  = '{0, 0, 0, 64'd0,   1, 64'd520, 4};
    tv[9]  = '{0, 1, 0, 64'd0,   1, 64'd520, 4};
    tv[10] = '{0, 1, 1, 64'd536, 1, 64'd524, 3};

    idle(); t_rst = 1; cycle();
    mchk = 1;
    for (int i = 0; i < 11; i++) begin
      idle();
      t_rst = tv[i].rst; t_derdy = tv[i].derdy;
      cycle();
      chk("tv_req_v", 64'(obs_reqv), 64'(tv[i].e_reqv));
      if (tv[i].e_reqv)
        chk("tv_req_pc", obs_reqpc, tv[i].e_pc);
      chk("tv_de_v", 64'(obs_dev), 64'(tv[i].e_dev));
      if (tv[i].e_dev)
        chk("tv_de_pc", obs_depc, tv[i].e_depc);
      chk("tv_count", 64'(obs_cnt), 64'(tv[i].e_cnt));
    end

    // late responses squashed by a redirect
    lat_lo = 3; lat_hi = 3;
    idle(); t_rst = 1; cycle();
    idle(); cycle(); cycle();
    t_redir = 1; t_rpc = 64'h1000; cycle();
    idle(); cycle();
    chk("redir_empty", 64'(obs_cnt), 64'd0);
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      cycle();
      if (obs_dev) begin
        chk("redir_first_pc", obs_depc, 64'h1000);
        seen = 1;
      end
    end
    if (!seen) chk("redir_timeout", 64'd0, 64'd1);

    // context switch wins over redirect
    t_cs = 1; t_csvec = 64'h3000;
    t_redir = 1; t_rpc = 64'h4000; cycle();
    idle(); cycle();
    chk("cs_req_v", 64'(obs_reqv), 64'd1);
    chk("cs_req_pc", obs_reqpc, 64'h3000);
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      cycle();
      if (obs_dev) begin
        chk("cs_first_pc", obs_depc, 64'h3000);
        seen = 1;
      end
    end
    if (!seen) chk("cs_timeout", 64'd0, 64'd1);

    // misaligned target: one fault entry, then halt
    lat_lo = 1; lat_hi = 1;
    t_redir = 1; t_rpc = 64'h1002; cycle();
    idle(); nreq = 0; niam = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (obs_reqv) nreq++;
      if (obs_dev && obs_iam) begin
        niam++;
        chk("mis_pc", obs_depc, 64'h1002);
        chk("mis_ir", 64'(obs_deir), 64'd0);
      end
    end
    chk("mis_noreq", 64'(nreq), 64'd0);
    chk("mis_one_iam", 64'(niam), 64'd1);
    t_redir = 1; t_rpc = 64'h2000; cycle();
    idle(); cycle();
    chk("mis_resume_v", 64'(obs_reqv), 64'd1);
    chk("mis_resume_pc", obs_reqpc, 64'h2000);

    // stall drains the queue without new requests
    t_rst = 1; cycle();
    idle(); t_derdy = 0;
    for (int k = 0; k < 20 && obs_cnt != 4; k++) cycle();
    chk("stall_full", 64'(obs_cnt), 64'd4);
    t_stall = 1; t_derdy = 1; nreq = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (obs_reqv) nreq++;
    end
    chk("stall_noreq", 64'(nreq), 64'd0);
    chk("stall_drained", 64'(obs_cnt), 64'd0);
    idle(); cycle();
    chk("stall_resume_v", 64'(obs_reqv), 64'd1);
    chk("stall_resume_pc", obs_reqpc, 64'd528);

    // reset with requests in flight
    lat_lo = 5; lat_hi = 5;
    t_rst = 1; cycle();
    idle(); cycle(); cycle(); cycle();
    chk("rst_outstanding", 64'(mf.size()), 64'd3);
    t_rst = 1; cycle();
    idle(); cycle();
    chk("rst_de_v", 64'(obs_dev), 64'd0);
    chk("rst_count", 64'(obs_cnt), 64'd0);
    chk("rst_req_pc", obs_reqpc, RPC);

    // randomized traffic against the model
    lat_lo = 1; lat_hi = 4;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 199));
      t_rst = (r < 2);
      t_cs = (r >= 2 && r < 6);
      t_redir = (r >= 6 && r < 16);
      t_csvec = 64'($urandom_range(0, 1023)) << 2;
      t_rpc = 64'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 7) == 0) t_rpc[1] = 1'b1;
      if ($urandom_range(0, 15) == 0)
        t_rpc = 64'hFFFF_FFFF_FFFF_FFF0;
      t_stall = ($urandom_range(0, 4) == 0);
      t_rdy = ($urandom_range(0, 3) != 0);
      t_derdy = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
